// File: rtl/gpio_pulse_checker.sv
// Multi-channel GPIO pulse checker: each enabled channel must show TOGGLES_REQ filtered pulses before timeout.
// Latency: io edge -> filter output SYNC_STAGES+FILTER_CYCLES cycles; last counted fall -> done_o two cycles later.
module gpio_pulse_checker #(
  parameter int CHANNELS      = 4,
  parameter int TOGGLES_REQ   = 2,
  parameter int TIMEOUT_W     = 24,
  parameter int TIMEOUT       = 60000,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic                                        wb_clk_i,
  input  logic                                        wb_rst_i,
  input  logic                                        start_i,
  input  logic                                        abort_i,
  input  logic [CHANNELS-1:0]                         chan_en_i,
  input  logic [CHANNELS-1:0]                         io_i,
  output logic                                        busy_o,
  output logic                                        done_o,
  output logic                                        pass_o,
  output logic                                        fail_o,
  output logic                                        timeout_o,
  output logic [CHANNELS-1:0]                         chan_ok_o,
  output logic [CHANNELS*$clog2(TOGGLES_REQ+1)-1:0]   pulse_cnt_o
);

  localparam int CW = $clog2(TOGGLES_REQ + 1);
  localparam int FW = $clog2(FILTER_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0][FW-1:0]          fcnt_q, fcnt_d;
  logic [CHANNELS-1:0]                  filt_q, filt_d;
  logic [CHANNELS-1:0]                  filt_prev_q, filt_prev_d;
  logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  rise_q, rise_d;
  logic [CHANNELS-1:0]                  en_q, en_d;
  logic [TIMEOUT_W-1:0]                 tmo_q, tmo_d;
  logic [1:0]                           state_q, state_d;
  logic                                 pass_q, pass_d;
  logic                                 fail_q, fail_d;
  logic                                 timeout_q, timeout_d;

  logic [CHANNELS-1:0] synced, rise_edge, fall_edge, ok;
  logic                all_ok;

  // Input path runs in every state so the filtered level is already valid when a run starts.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], io_i};
    synced      = sync_q[SYNC_STAGES-1];
    filt_prev_d = filt_q;
    fcnt_d      = '0;
    filt_d      = filt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (synced[i] != filt_q[i]) begin
        if (fcnt_q[i] == FW'(FILTER_CYCLES - 1)) filt_d[i] = synced[i];
        else                                     fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
    rise_edge = filt_q & ~filt_prev_q;
    fall_edge = ~filt_q & filt_prev_q;
  end

  always_comb begin
    ok = '0;
    for (int i = 0; i < CHANNELS; i++) ok[i] = (cnt_q[i] == CW'(TOGGLES_REQ));
    all_ok = &(ok | ~en_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rise_d    = rise_q;
    en_d      = en_q;
    tmo_d     = tmo_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          rise_d    = '0;
          tmo_d     = '0;
          en_d      = chan_en_i;
          if (chan_en_i != '0) begin
            state_d = S_RUN;
          end else begin
            fail_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          for (int i = 0; i < CHANNELS; i++) begin
            if (en_q[i]) begin
              if (rise_edge[i]) begin
                rise_d[i] = 1'b1;
              end else if (fall_edge[i] && rise_q[i]) begin
                rise_d[i] = 1'b0;
                if (!ok[i]) cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
          end
          // Completion is checked first so a same-cycle timeout still reports a pass.
          if (all_ok) begin
            pass_d  = 1'b1;
            state_d = S_DONE;
          end else if (tmo_q == TIMEOUT_W'(TIMEOUT - 1)) begin
            fail_d    = 1'b1;
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q      <= '0;
      fcnt_q      <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      cnt_q       <= '0;
      rise_q      <= '0;
      en_q        <= '0;
      tmo_q       <= '0;
      state_q     <= S_IDLE;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      fcnt_q      <= fcnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      cnt_q       <= cnt_d;
      rise_q      <= rise_d;
      en_q        <= en_d;
      tmo_q       <= tmo_d;
      state_q     <= state_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy_o      = (state_q == S_RUN);
  assign done_o      = (state_q == S_DONE);
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign timeout_o   = timeout_q;
  assign chan_ok_o   = ok;
  assign pulse_cnt_o = cnt_q;

endmodule
